// File: rtl/riscv_fetch_buffer.sv
// Instruction fetch front-end: credit-limited word fetch, in-order response
// buffering with PCs, decode handshake, and redirect flush with stale-response discard.
module riscv_fetch_buffer #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [BUS_WIDTH-1:0] RESET_PC = {BUS_WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic [BUS_WIDTH-1:0] mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  input  logic                 redirect,
  input  logic [BUS_WIDTH-1:0] redirect_pc,
  output logic                 inst_valid,
  output logic [BUS_WIDTH-1:0] inst,
  output logic [BUS_WIDTH-1:0] inst_pc,
  input  logic                 inst_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [BUS_WIDTH-1:0] WORD_ZERO = {BUS_WIDTH{1'b0}};
  localparam logic [BUS_WIDTH-1:0] PC_ONE = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

  logic [BUS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [BUS_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic [CNT_W-1:0]     discard_q, discard_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [BUS_WIDTH-1:0] pc_mem_q [DEPTH];
  logic [BUS_WIDTH-1:0] pc_mem_d [DEPTH];
  logic [BUS_WIDTH-1:0] data_mem_q [DEPTH];
  logic [BUS_WIDTH-1:0] data_mem_d [DEPTH];

  logic [CNT_W:0] credit_sum_s;
  logic           req_s;
  logic           grant_s;
  logic           rsp_s;
  logic           drop_s;
  logic           push_s;
  logic           pop_s;

  // Handshake qualifiers; buffered plus in-flight words never exceed DEPTH.
  always_comb begin
    credit_sum_s = {1'b0, count_q} + {1'b0, outstanding_q};
    req_s   = !reset && !redirect && (credit_sum_s < CREDIT_MAX);
    grant_s = req_s && mem_gnt;
    rsp_s   = mem_rvalid && (outstanding_q != CNT_ZERO);
    drop_s  = rsp_s && (discard_q != CNT_ZERO);
    push_s  = rsp_s && !drop_s && !redirect;
    pop_s   = (count_q != CNT_ZERO) && inst_ready && !redirect;
  end

  // Next-state for PCs, counters and FIFO pointers.
  always_comb begin
    outstanding_d = outstanding_q + (grant_s ? CNT_ONE : CNT_ZERO) - (rsp_s ? CNT_ONE : CNT_ZERO);
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      // A response landing in the redirect cycle is stale too, so it is not counted.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      discard_d  = outstanding_q - (rsp_s ? CNT_ONE : CNT_ZERO);
      count_d    = CNT_ZERO;
      rd_ptr_d   = PTR_ZERO;
      wr_ptr_d   = PTR_ZERO;
    end else begin
      if (grant_s) begin
        fetch_pc_d = fetch_pc_q + PC_ONE;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (drop_s) begin
        discard_d = discard_q - CNT_ONE;
      end else begin
        discard_d = discard_q;
      end
      if (push_s) begin
        resp_pc_d = resp_pc_q + PC_ONE;
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
      end else begin
        resp_pc_d = resp_pc_q;
        wr_ptr_d  = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage write path.
  always_comb begin
    pc_mem_d   = pc_mem_q;
    data_mem_d = data_mem_q;
    if (push_s) begin
      pc_mem_d[wr_ptr_q]   = resp_pc_q;
      data_mem_d[wr_ptr_q] = mem_rdata;
    end else begin
      pc_mem_d   = pc_mem_q;
      data_mem_d = data_mem_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= CNT_ZERO;
      discard_q     <= CNT_ZERO;
      count_q       <= CNT_ZERO;
      rd_ptr_q      <= PTR_ZERO;
      wr_ptr_q      <= PTR_ZERO;
      pc_mem_q      <= '{default: WORD_ZERO};
      data_mem_q    <= '{default: WORD_ZERO};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pc_mem_q      <= pc_mem_d;
      data_mem_q    <= data_mem_d;
    end
  end

  // Output drive; the head reads as zero while the FIFO is empty.
  always_comb begin
    mem_req    = req_s;
    mem_addr   = fetch_pc_q;
    inst_valid = (count_q != CNT_ZERO);
    if (count_q != CNT_ZERO) begin
      inst    = data_mem_q[rd_ptr_q];
      inst_pc = pc_mem_q[rd_ptr_q];
    end else begin
      inst    = WORD_ZERO;
      inst_pc = WORD_ZERO;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Directed bench for riscv_fetch_buffer: in-order memory model with variable
// latency returning addr+0x100, and a log of every word accepted by decode.
module tb_riscv_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; int cyc; } dlv_t;

  pend_t pend[$];
  dlv_t  dlog[$];
  int    cyc = 0;
  int    grants = 0;
  int    lat = 1;
  int    rel_cyc = 0;
  int    c_r = 0;
  int    errors = 0;
  int    checks = 0;

  riscv_fetch_buffer #(.BUS_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  // Memory model (in-order, fixed latency from grant) plus grant/delivery monitor.
  always @(posedge clk or negedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end else if (clk) begin
      cyc++;
      if (mem_rvalid) pend.delete(0);
      if (mem_req && mem_gnt) begin
        pend.push_back('{addr: mem_addr, due: cyc + lat});
        grants++;
      end
      if (inst_valid && inst_ready && !redirect)
        dlog.push_back('{pc: inst_pc, data: inst, cyc: cyc});
    end else begin
      if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend[0].addr + 32'h100;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    dlog.delete();
    grants = 0;
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_log(input int n, input string name);
    for (int i = 0; i < 60 && dlog.size() < n; i++) @(negedge clk);
    checks++;
    if (dlog.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d deliveries, expected %0d", name, dlog.size(), n);
    end
  endtask

  task automatic test_reset();
    lat = 1; mem_gnt = 1'b1; inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
    @(negedge clk);
    dlog.delete(); grants = 0; reset = 1'b0; rel_cyc = cyc;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 0", mem_addr); end
    @(negedge clk); #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL valid_cycle1: got %b expected 0", inst_valid); end
    @(negedge clk); #1;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL valid_cycle2: got %b expected 1", inst_valid); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL first_pc: got %h expected 0", inst_pc); end
    checks++; if (inst !== 32'h100) begin errors++; $display("FAIL first_inst: got %h expected 100", inst); end
  endtask

  task automatic test_backpressure();
    repeat (8) @(negedge clk);
    #1;
    checks++; if (grants !== 4) begin errors++; $display("FAIL bp_grants: got %0d expected 4", grants); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b expected 0", mem_req); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", inst_valid); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h expected 0", inst_pc); end
    checks++; if (inst !== 32'h100) begin errors++; $display("FAIL bp_head_inst: got %h expected 100", inst); end
    inst_ready = 1'b1;
    wait_log(8, "bp");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dlog.size() <= i || dlog[i].pc !== 32'(i) || dlog[i].data !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL bp_drain[%0d]: got pc=%h inst=%h expected pc=%h inst=%h", i,
                 (dlog.size() > i) ? dlog[i].pc : 32'hx, (dlog.size() > i) ? dlog[i].data : 32'hx,
                 32'(i), 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_straight_line();
    lat = 1; inst_ready = 1'b1; mem_gnt = 1'b1;
    do_reset();
    wait_log(8, "straight");
    checks++;
    if (dlog.size() < 1 || dlog[0].cyc !== rel_cyc + 3) begin
      errors++;
      $display("FAIL straight_first_cycle: got %0d expected %0d", (dlog.size() > 0) ? dlog[0].cyc : -1, rel_cyc + 3);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dlog.size() <= i || dlog[i].pc !== 32'(i) || dlog[i].data !== 32'h100 + 32'(i) ||
          dlog[i].cyc !== rel_cyc + 3 + i) begin
        errors++;
        $display("FAIL straight[%0d]: got pc=%h inst=%h cyc=%0d expected pc=%h inst=%h cyc=%0d", i,
                 (dlog.size() > i) ? dlog[i].pc : 32'hx, (dlog.size() > i) ? dlog[i].data : 32'hx,
                 (dlog.size() > i) ? dlog[i].cyc : -1, 32'(i), 32'h100 + 32'(i), rel_cyc + 3 + i);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    lat = 3; inst_ready = 1'b1; mem_gnt = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h40; c_r = cyc;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_req_in_redirect: got %b expected 0", mem_req); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_flushed: got %b expected 0", inst_valid); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rd_req_after: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL rd_addr_after: got %h expected 40", mem_addr); end
    wait_log(2, "rd");
    checks++;
    if (dlog.size() < 1 || dlog[0].pc !== 32'h40 || dlog[0].data !== 32'h140 || dlog[0].cyc !== c_r + 6) begin
      errors++;
      $display("FAIL rd_first: got pc=%h inst=%h cyc=%0d expected pc=40 inst=140 cyc=%0d",
               (dlog.size() > 0) ? dlog[0].pc : 32'hx, (dlog.size() > 0) ? dlog[0].data : 32'hx,
               (dlog.size() > 0) ? dlog[0].cyc : -1, c_r + 6);
    end
    checks++;
    if (dlog.size() < 2 || dlog[1].pc !== 32'h41 || dlog[1].data !== 32'h141) begin
      errors++;
      $display("FAIL rd_second: got pc=%h inst=%h expected pc=41 inst=141",
               (dlog.size() > 1) ? dlog[1].pc : 32'hx, (dlog.size() > 1) ? dlog[1].data : 32'hx);
    end
  endtask

  task automatic test_redirect_rvalid();
    lat = 3; inst_ready = 1'b1; mem_gnt = 1'b1;
    do_reset();
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h80; mem_gnt = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rv_req_in_redirect: got %b expected 0", mem_req); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rv_word_dropped: got %b expected 0", inst_valid); end
    checks++; if (mem_addr !== 32'h80) begin errors++; $display("FAIL rv_addr_after: got %h expected 80", mem_addr); end
    wait_log(2, "rv");
    checks++;
    if (dlog.size() < 1 || dlog[0].pc !== 32'h80 || dlog[0].data !== 32'h180) begin
      errors++;
      $display("FAIL rv_first: got pc=%h inst=%h expected pc=80 inst=180",
               (dlog.size() > 0) ? dlog[0].pc : 32'hx, (dlog.size() > 0) ? dlog[0].data : 32'hx);
    end
    checks++;
    if (dlog.size() < 2 || dlog[1].pc !== 32'h81 || dlog[1].data !== 32'h181) begin
      errors++;
      $display("FAIL rv_second: got pc=%h inst=%h expected pc=81 inst=181",
               (dlog.size() > 1) ? dlog[1].pc : 32'hx, (dlog.size() > 1) ? dlog[1].data : 32'hx);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_data [3];
    exp_pc   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    exp_data = '{32'h0000_00FE, 32'h0000_00FF, 32'h0000_0100};
    lat = 1; inst_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; dlog.delete();
    @(negedge clk);
    redirect = 1'b0;
    wait_log(3, "wrap");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dlog.size() <= i || dlog[i].pc !== exp_pc[i] || dlog[i].data !== exp_data[i]) begin
        errors++;
        $display("FAIL wrap[%0d]: got pc=%h inst=%h expected pc=%h inst=%h", i,
                 (dlog.size() > i) ? dlog[i].pc : 32'hx, (dlog.size() > i) ? dlog[i].data : 32'hx,
                 exp_pc[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    lat = 1; inst_ready = 1'b0; mem_gnt = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    #1;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", inst_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", inst_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b expected 0", mem_req); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL ar_inst_pc: got %h expected 0", inst_pc); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL ar_inst: got %h expected 0", inst); end
    repeat (2) @(negedge clk);
    dlog.delete(); reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ar_req_after: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL ar_addr_after: got %h expected 0", mem_addr); end
    inst_ready = 1'b1;
    wait_log(1, "ar");
    checks++;
    if (dlog.size() < 1 || dlog[0].pc !== 32'h0 || dlog[0].data !== 32'h100) begin
      errors++;
      $display("FAIL ar_first: got pc=%h inst=%h expected pc=0 inst=100",
               (dlog.size() > 0) ? dlog[0].pc : 32'hx, (dlog.size() > 0) ? dlog[0].data : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_straight_line();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_wrap();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_fetch_buffer.md
# riscv_fetch_buffer

Instruction fetch front-end for the riscv pipeline core. It generates word-addressed instruction-memory requests, tolerates variable memory latency, and buffers returned words with their PCs in a small FIFO. It hands the words to the decode stage through a valid/ready handshake. A redirect from the execute stage (taken branch or jump) flushes the buffer and restarts fetch at the new PC. Responses to requests issued before the redirect are discarded.

## Interface
- BUS_WIDTH, 32, width of PC, address and instruction
- DEPTH, 4, FIFO entries and maximum in-flight plus buffered words; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mem_req  out  1  fetch request valid
- mem_addr  out  BUS_WIDTH  word address of request
- mem_gnt  in  1  memory accepts request this cycle (only meaningful with mem_req)
- mem_rvalid  in  1  response word valid; responses return in request order
- mem_rdata  in  BUS_WIDTH  response instruction word
- redirect  in  1  flush and restart fetch (is_taken)
- redirect_pc  in  BUS_WIDTH  new fetch PC (branch target)
- inst_valid  out  1  FIFO head holds a valid instruction
- inst  out  BUS_WIDTH  FIFO head instruction
- inst_pc  out  BUS_WIDTH  PC of FIFO head
- inst_ready  in  1  decode consumes head when inst_valid is high

## Operation
- Clock and reset: one clock domain, clk; reset is asynchronous and active-high.
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of next accepted response.
  - outstanding: granted requests whose response has not yet returned; width clog2(DEPTH)+1.
  - discard: responses still to be dropped; same width as outstanding.
  - FIFO of DEPTH entries {pc, data}, with count.
- PC arithmetic is word-addressed: +1 per instruction, modulo 2^BUS_WIDTH. Wrap from all-ones to 0 is legal and silent.
- Request:
  - mem_req = !reset && !redirect && (count + outstanding < DEPTH). This credit rule guarantees the FIFO never overflows.
  - mem_addr = fetch_pc.
  - On mem_req && mem_gnt: fetch_pc+1 and outstanding+1.
- Response, on mem_rvalid:
  - outstanding−1.
  - If discard≠0: discard−1 and the word is dropped.
  - Otherwise: push {resp_pc, mem_rdata} and resp_pc+1.
- Pop: on inst_valid && inst_ready, the head leaves the FIFO.
  - inst_valid = (count≠0).
  - inst and inst_pc come directly from the head entry.
  - Both read 0 when the FIFO is empty.
- Redirect, for one cycle:
  - FIFO emptied (count←0, pointers reset).
  - fetch_pc and resp_pc ← redirect_pc.
  - discard ← outstanding − mem_rvalid. A response arriving in the redirect cycle is itself dropped.
  - Any push or pop in that cycle is ignored.
  - No request is issued in the redirect cycle.
- Back-to-back redirects:
  - Each redirect recomputes discard from the current outstanding.
  - The last redirect wins.
- Pipeline behaviour: simultaneous push and pop leaves count unchanged. Push to a FIFO that is full before the pop cannot occur, by the credit rule.
- Memory protocol violation: mem_rvalid with outstanding=0 is ignored. The verifier flags it with an assertion.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC.
  - inst_valid=0, inst=0, inst_pc=0.
  - fetch_pc=resp_pc=RESET_PC.
  - outstanding=discard=count=0.
- Reset asserted mid-operation clears all state immediately (asynchronously). In-flight responses after reset release are not discarded; the memory must also be reset.
- First request: mem_req is high in the first cycle after reset deassertion, with mem_addr=RESET_PC.
- Latency: rvalid at edge N pushes the word at edge N, so inst_valid is high in the cycle after.
  - With zero-wait memory (gnt always high, rvalid one cycle after gnt), the first inst_valid is 2 cycles after reset release.
  - Sustained throughput is 1 instruction/cycle when inst_ready stays high.
- Redirect at cycle R:
  - mem_req rises with mem_addr=redirect_pc at R+1.
  - The first new instruction appears no earlier than R+3 with zero-wait memory.
- Backpressure: with inst_ready low, at most DEPTH words are requested, then mem_req drops. The head is held stable (inst, inst_pc unchanged) until popped.

## Test plan
- Straight-line: RESET_PC=0, zero-wait memory returning data=addr+0x100, inst_ready=1 → inst_pc 0,1,2,3… on consecutive cycles with inst=0x100,0x101,…, no gaps after the first.
- Backpressure: inst_ready=0 for 10 cycles → exactly 4 grants (DEPTH=4), then mem_req=0. Raise inst_ready → pcs 0..3 drain in order, then fetch resumes at 4.
- Redirect with in-flight: memory latency 3 cycles, 2 outstanding, redirect_pc=0x40 → the 2 old responses are dropped, FIFO empty, next inst_pc=0x40, then 0x41.
- Simultaneous redirect and rvalid: redirect at the cycle of the last outstanding response → that word is dropped, discard=0, and the first delivered inst_pc equals redirect_pc.
- Wrap-around: redirect_pc=0xFFFFFFFE → inst_pc sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Async reset mid-stream: assert reset between clock edges with FIFO at count=3 → inst_valid=0 and mem_req=0 immediately. After release, the first mem_addr=RESET_PC.
